por_sequencer: RTL and testbench

POR_SEQUENCER -- requirements
Module: por_sequencer

---
 rtl/por_sequencer_pkg.sv | 65 ++++++
 rtl/por_sync.sv | 26 ++
 rtl/por_sequencer.sv | 136 +++++++++++++
 tb/tb_por_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/por_sequencer_pkg.sv
// Shared types and defaults for the power-on-reset sequencer.
package por_sequencer_pkg;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_HOLD_CYCLES     = 64;
   localparam int unsigned DEF_STAGE_GAP       = 8;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEF_SW_PULSE        = 32;

   typedef enum logic [2:0] {
      ASSERT    = 3'd0,
      HOLD      = 3'd1,
      RELEASE_H = 3'd2,
      RUN       = 3'd3,
      SW_RESET  = 3'd4
   } por_state_e;

   typedef struct packed {
      logic porb_h;
      logic porb_l;
      logic por_l;
      logic sw_reset_busy;
      logic por_done;
   } por_out_t;

   // Largest of the four counter limits; sizes the shared counters.
   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Output pattern belonging to each state; por_l is always the inverse of porb_l.
   function automatic por_out_t decode_outputs(input por_state_e st);
      por_out_t o;
      o = '0;
      case (st)
         RELEASE_H: begin
            o.porb_h = 1'b1;
            o.porb_l = 1'b0;
         end
         RUN: begin
            o.porb_h   = 1'b1;
            o.porb_l   = 1'b1;
            o.por_done = 1'b1;
         end
         SW_RESET: begin
            o.porb_h        = 1'b1;
            o.porb_l        = 1'b0;
            o.sw_reset_busy = 1'b1;
         end
         default: begin
            o.porb_h = 1'b0;
            o.porb_l = 1'b0;
         end
      endcase
      o.por_l = ~o.porb_l;
      return o;
   endfunction

endpackage

// File: rtl/por_sync.sv
// Multi-flop synchronizer for the asynchronous external reset pin.
module por_sync
   import por_sequencer_pkg::*;
#(
   parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
   input  logic clock,
   input  logic resetb,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the pin through STAGES flops; cleared by the block reset.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         ff <= '0;
      end else begin
         ff <= STAGES'({ff, d});
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/por_sequencer.sv
// Power-on-reset sequencer: holds both domains in reset until the external
// pin has been stably high, releases 3.3V then 1.8V, debounces pin drops in
// RUN and generates software reset pulses on the 1.8V domain.
module por_sequencer
   import por_sequencer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SW_PULSE        = DEF_SW_PULSE
) (
   input  logic clock,
   input  logic resetb,
   input  logic ext_resetb_pin,
   input  logic sw_reset_req,
   output logic porb_h,
   output logic porb_l,
   output logic por_l,
   output logic sw_reset_busy,
   output logic por_done
);

   localparam int unsigned CNT_W =
      $clog2(max4(HOLD_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES, SW_PULSE)) + 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_PULSE - 1);

   logic             pin_sync;
   por_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] low_q, low_d;
   por_out_t         out_q, out_d;

   // Saturating increment so no counter can ever wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   por_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock  (clock),
      .resetb (resetb),
      .d      (ext_resetb_pin),
      .q      (pin_sync)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         low_q   <= '0;
         out_q   <= decode_outputs(ASSERT);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         low_q   <= low_d;
         out_q   <= out_d;
      end
   end

   // Next-state and counter logic; the low counter only runs in RUN/SW_RESET.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      low_d   = '0;
      out_d   = decode_outputs(state_q);

      case (state_q)
         ASSERT: begin
            state_d = HOLD;
            cnt_d   = '0;
         end

         HOLD: begin
            if (!pin_sync) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RELEASE_H;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end

         RELEASE_H: begin
            if (!pin_sync) begin
               state_d = ASSERT;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end

         RUN, SW_RESET: begin
            low_d = pin_sync ? '0 : sat_inc(low_q);
            if (!pin_sync && (low_q == DEB_LAST)) begin
               // Debounced pin drop beats any software request.
               state_d = ASSERT;
               cnt_d   = '0;
               low_d   = '0;
            end else if (state_q == RUN) begin
               if (sw_reset_req) begin
                  state_d = SW_RESET;
                  cnt_d   = '0;
               end
            end else if (cnt_q == SW_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end

         default: begin
            state_d = ASSERT;
            cnt_d   = '0;
         end
      endcase
   end

   assign porb_h        = out_q.porb_h;
   assign porb_l        = out_q.porb_l;
   assign por_l         = out_q.por_l;
   assign sw_reset_busy = out_q.sw_reset_busy;
   assign por_done      = out_q.por_done;

endmodule

// File: tb/tb_por_sequencer.sv
// Self-checking bench for por_sequencer: directed sequences plus random
// stimulus compared every cycle against a timestamp-based behavioural model.
module tb_por_sequencer;

   localparam int HOLD_N = 8;
   localparam int GAP_N  = 4;
   localparam int DEB_N  = 3;
   localparam int SW_N   = 5;

   localparam int M_ASSERT = 0;
   localparam int M_HOLD   = 1;
   localparam int M_RELH   = 2;
   localparam int M_RUN    = 3;
   localparam int M_SW     = 4;

   localparam logic [4:0] PAT_RESET = 5'b00100;

   logic clock  = 1'b0;
   logic resetb = 1'b0;
   logic pin    = 1'b1;
   logic req    = 1'b0;
   logic porb_h, porb_l, por_l, sw_reset_busy, por_done;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: current phase, when it began, and run lengths of the synchronized pin.
   int k          = 0;
   int mode       = M_ASSERT;
   int mode_since = 0;
   int grp_since  = 0;
   int hi_run     = 0;
   int lo_run     = 0;
   int hist[$];
   logic [4:0] exp_out = PAT_RESET;

   always #5 clock = ~clock;

   por_sequencer #(
      .SYNC_STAGES     (2),
      .HOLD_CYCLES     (HOLD_N),
      .STAGE_GAP       (GAP_N),
      .DEBOUNCE_CYCLES (DEB_N),
      .SW_PULSE        (SW_N)
   ) dut (
      .clock          (clock),
      .resetb         (resetb),
      .ext_resetb_pin (pin),
      .sw_reset_req   (req),
      .porb_h         (porb_h),
      .porb_l         (porb_l),
      .por_l          (por_l),
      .sw_reset_busy  (sw_reset_busy),
      .por_done       (por_done)
   );

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // {porb_h, porb_l, por_l, sw_reset_busy, por_done} for each model phase.
   function automatic logic [4:0] pattern(input int m);
      case (m)
         M_RELH:  return 5'b10100;
         M_RUN:   return 5'b11001;
         M_SW:    return 5'b10110;
         default: return PAT_RESET;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
      end
   endtask

   // Advance the model by one clock edge using the inputs sampled at it.
   task automatic model_step();
      int s;
      int tin;
      k++;
      if (!resetb) begin
         mode       = M_ASSERT;
         mode_since = k;
         hist       = '{0, 0};
         hi_run     = 0;
         lo_run     = 0;
         exp_out    = PAT_RESET;
         return;
      end
      exp_out = pattern(mode);
      s = hist.pop_front();
      hist.push_back(int'(pin));
      if (s != 0) begin
         hi_run++;
         lo_run = 0;
      end else begin
         lo_run++;
         hi_run = 0;
      end
      tin = k - mode_since;
      case (mode)
         M_ASSERT: begin
            mode = M_HOLD; mode_since = k;
         end
         M_HOLD: begin
            if (s != 0 && imin(hi_run, tin) >= HOLD_N) begin
               mode = M_RELH; mode_since = k;
            end
         end
         M_RELH: begin
            if (s == 0) begin
               mode = M_ASSERT; mode_since = k;
            end else if (tin == GAP_N) begin
               mode = M_RUN; mode_since = k; grp_since = k;
            end
         end
         default: begin
            if (imin(lo_run, k - grp_since) >= DEB_N) begin
               mode = M_ASSERT; mode_since = k;
            end else if (mode == M_RUN && req) begin
               mode = M_SW; mode_since = k;
            end else if (mode == M_SW && tin == SW_N) begin
               mode = M_RUN; mode_since = k;
            end
         end
      endcase
   endtask

   // One cycle: drive on the falling edge, step the model, check after the rise.
   task automatic tick(input logic p, input logic r, input logic rb);
      @(negedge clock);
      pin    = p;
      req    = r;
      resetb = rb;
      @(posedge clock);
      model_step();
      #1;
      chk("outputs", {porb_h, porb_l, por_l, sw_reset_busy, por_done}, exp_out);
   endtask

   initial begin
      int   rise_h, rise_l, cnt, cnt_l, lowh, fall, burst;
      logic p, r, rb;

      // Reset and nominal power-up.
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      chk("reset_state", {porb_h, porb_l, por_l, sw_reset_busy, por_done}, PAT_RESET);
      rise_h = -1;
      rise_l = -1;
      for (int c = 1; c <= 20; c++) begin
         tick(1'b1, 1'b0, 1'b1);
         if (porb_h === 1'b1 && rise_h < 0) rise_h = c;
         if (porb_l === 1'b1 && rise_l < 0) rise_l = c;
      end
      chk("porb_h_rise", rise_h, 11);
      chk("porb_l_rise", rise_l, 15);
      chk("por_done_run", por_done, 1'b1);

      // One-cycle pin drop while the hold count is 5.
      repeat (2) tick(1'b1, 1'b0, 1'b0);
      rise_h = -1;
      for (int c = 1; c <= 25; c++) begin
         tick((c == 6) ? 1'b0 : 1'b1, 1'b0, 1'b1);
         if (porb_h === 1'b1 && rise_h < 0) rise_h = c;
      end
      chk("hold_restart_rise", rise_h, 17);

      // Two-cycle glitch in RUN is filtered.
      cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         tick((c <= 2) ? 1'b0 : 1'b1, 1'b0, 1'b1);
         if (por_done !== 1'b1) cnt++;
      end
      chk("glitch2_filtered", cnt, 0);

      // Three-cycle drop re-triggers the full sequence.
      fall = -1;
      for (int c = 1; c <= 25; c++) begin
         tick((c <= 3) ? 1'b0 : 1'b1, 1'b0, 1'b1);
         if (porb_h === 1'b0 && fall < 0) fall = c;
      end
      chk("debounce_fall", fall, 6);
      chk("rerun_done", por_done, 1'b1);

      // Software pulse with a second request mid-pulse.
      cnt   = 0;
      cnt_l = 0;
      lowh  = 0;
      for (int c = 1; c <= 12; c++) begin
         tick(1'b1, (c == 1 || c == 3) ? 1'b1 : 1'b0, 1'b1);
         if (sw_reset_busy === 1'b1) cnt++;
         if (porb_l === 1'b0) cnt_l++;
         if (porb_h !== 1'b1) lowh++;
      end
      chk("sw_busy_len", cnt, SW_N);
      chk("sw_porb_l_len", cnt_l, SW_N);
      chk("sw_porb_h_held", lowh, 0);

      // Block reset during SW_RESET and during RELEASE_H.
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      chk("in_sw_before_rst", sw_reset_busy, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      chk("rst_in_sw", {porb_h, porb_l, por_l, sw_reset_busy, por_done}, PAT_RESET);
      for (int c = 1; c <= 11; c++) tick(1'b1, 1'b0, 1'b1);
      chk("in_relh_before_rst", {porb_h, porb_l}, 2'b10);
      tick(1'b1, 1'b0, 1'b0);
      chk("rst_in_relh", {porb_h, porb_l, por_l, sw_reset_busy, por_done}, PAT_RESET);

      // Random pin bursts, software requests and occasional block resets.
      burst = 0;
      for (int i = 0; i < 4000; i++) begin
         if (burst > 0) begin
            burst--;
            p = 1'b0;
         end else if ($urandom_range(0, 99) < 4) begin
            burst = int'($urandom_range(0, 4));
            p = 1'b0;
         end else begin
            p = 1'b1;
         end
         r  = ($urandom_range(0, 99) < 6);
         rb = ($urandom_range(0, 999) >= 4);
         tick(p, r, rb);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
